// File: rtl/fp_div_pkg.sv
// Shared types and sizing helpers for the sequential signed fixed-point divider.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fp_div_state_t;

    // One quotient bit per dividend bit; the dividend is the integer operand widened by the fraction.
    function automatic int div_iters(input int width, input int frac);
        return width + frac;
    endfunction

    function automatic int iter_cnt_w(input int width, input int frac);
        return $clog2(div_iters(width, frac)) + 1;
    endfunction

endpackage

// File: rtl/fp_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module fp_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // The kept remainder is always below the divisor, so the low WIDTH bits of the difference are exact.
    assign shifted = {rem_in, dvd_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_fp_sdiv.sv
// Multi-cycle signed Q(INT).(FRAC) restoring divider with go/done handshake and fixed latency.
// Optional macro FP_SDIV_DBZ_FLAG_EN adds a registered div_by_zero output.
module seq_fp_sdiv
    import fp_div_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
`ifdef FP_SDIV_DBZ_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int N        = div_iters(WIDTH, FRAC_WIDTH);
    localparam int CW       = iter_cnt_w(WIDTH, FRAC_WIDTH);
    localparam int SIGN_BIT = INT_WIDTH + FRAC_WIDTH - 1;

    fp_div_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    // Only the low WIDTH quotient bits survive the wrap, so only those are kept.
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic             sign_l_q, sign_l_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] out_quotient_q, out_quotient_d;
    logic [WIDTH-1:0] out_remainder_q, out_remainder_d;
`ifdef FP_SDIV_DBZ_FLAG_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH-1:0] mag_l, mag_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_next;

    // Negating the most negative value yields 2^(WIDTH-1) when read as unsigned.
    assign mag_l     = left[SIGN_BIT]  ? (~left + 1'b1)  : left;
    assign mag_r     = right[SIGN_BIT] ? (~right + 1'b1) : right;
    assign quot_next = {quot_q[WIDTH-2:0], step_q};

    fp_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[N-1]),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        dvd_d           = dvd_q;
        div_d           = div_q;
        rem_d           = rem_q;
        quot_d          = quot_q;
        left_d          = left_q;
        sign_l_d        = sign_l_q;
        sign_r_d        = sign_r_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
`ifdef FP_SDIV_DBZ_FLAG_EN
        dbz_d           = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    dvd_d    = {mag_l, {FRAC_WIDTH{1'b0}}};
                    div_d    = mag_r;
                    rem_d    = '0;
                    quot_d   = '0;
                    left_d   = left;
                    sign_l_d = left[SIGN_BIT];
                    sign_r_d = right[SIGN_BIT];
                end
            end
            RUN: begin
                rem_d  = step_rem;
                quot_d = quot_next;
                dvd_d  = dvd_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // A zero divisor still runs the full schedule; its result is overridden here.
                    if (div_q == '0) begin
                        out_quotient_d  = '0;
                        out_remainder_d = left_q;
                    end else begin
                        out_quotient_d  = (sign_l_q ^ sign_r_q) ? (~quot_next + 1'b1) : quot_next;
                        out_remainder_d = sign_l_q ? (~step_rem + 1'b1) : step_rem;
                    end
`ifdef FP_SDIV_DBZ_FLAG_EN
                    dbz_d = (div_q == '0);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dvd_q           <= '0;
            div_q           <= '0;
            rem_q           <= '0;
            quot_q          <= '0;
            left_q          <= '0;
            sign_l_q        <= 1'b0;
            sign_r_q        <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
`ifdef FP_SDIV_DBZ_FLAG_EN
            dbz_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dvd_q           <= dvd_d;
            div_q           <= div_d;
            rem_q           <= rem_d;
            quot_q          <= quot_d;
            left_q          <= left_d;
            sign_l_q        <= sign_l_d;
            sign_r_q        <= sign_r_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
`ifdef FP_SDIV_DBZ_FLAG_EN
            dbz_q           <= dbz_d;
`endif
        end
    end

    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign done          = (state_q == DONE);
`ifdef FP_SDIV_DBZ_FLAG_EN
    assign div_by_zero   = dbz_q;
`endif

endmodule

// File: tb/tb_seq_fp_sdiv.sv
// Directed table-driven bench for seq_fp_sdiv (Q16.16); honours FP_SDIV_DBZ_FLAG_EN when defined.
module tb_seq_fp_sdiv;

    localparam int W       = 32;
    localparam int LAT     = 48;
    localparam int TIMEOUT = 120;

    logic          clk;
    logic          reset;
    logic          go;
    logic [W-1:0]  left;
    logic [W-1:0]  right;
    logic [W-1:0]  out_quotient;
    logic [W-1:0]  out_remainder;
    logic          done;
`ifdef FP_SDIV_DBZ_FLAG_EN
    logic          div_by_zero;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
    } vec_t;

    vec_t vecs[13];

    seq_fp_sdiv #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .done          (done)
`ifdef FP_SDIV_DBZ_FLAG_EN
        ,
        .div_by_zero   (div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives go for one edge (the start edge) unless hold is set.
    task automatic start_op(input logic [W-1:0] l, input logic [W-1:0] r, input bit hold);
        @(negedge clk);
        left  = l;
        right = r;
        go    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) go = 1'b0;
    endtask

    // Counts edges until done is seen; returns -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] r,
                                input logic [W-1:0] eq, input logic [W-1:0] er);
        check({tag, " quotient"}, out_quotient, eq);
        check({tag, " remainder"}, out_remainder, er);
`ifdef FP_SDIV_DBZ_FLAG_EN
        check({tag, " div_by_zero"}, W'(div_by_zero), W'(r == '0));
`endif
    endtask

    task automatic run_vec(input int idx);
        int    lat;
        string tag;
        tag = $sformatf("vec%0d", idx);
        start_op(vecs[idx].l, vecs[idx].r, 1'b0);
        wait_done(lat);
        check({tag, " latency"}, W'(lat), W'(LAT));
        check_result(tag, vecs[idx].r, vecs[idx].exp_q, vecs[idx].exp_r);
        @(posedge clk);
        #1;
        check({tag, " done one-cycle"}, W'(done), '0);
    endtask

    task automatic count_done(input int cycles, output int hits);
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (done) hits++;
        end
    endtask

    initial begin
        int lat;
        int hits;
        checks = 0;
        errors = 0;

        //          left          right         quotient      remainder
        vecs[0]  = '{32'h00060000, 32'h00020000, 32'h00030000, 32'h00000000}; //  6.0 /  2.0
        vecs[1]  = '{32'hFFF88000, 32'h00028000, 32'hFFFD0000, 32'h00000000}; // -7.5 /  2.5
        vecs[2]  = '{32'h00010000, 32'h00030000, 32'h00005555, 32'h00010000}; //  1.0 /  3.0
        vecs[3]  = '{32'h00050000, 32'h00000000, 32'h00000000, 32'h00050000}; //  5.0 /  0
        vecs[4]  = '{32'hFFFA0000, 32'hFFFE0000, 32'h00030000, 32'h00000000}; // -6.0 / -2.0
        vecs[5]  = '{32'h00070000, 32'hFFFE0000, 32'hFFFC8000, 32'h00000000}; //  7.0 / -2.0
        vecs[6]  = '{32'hFFFF0000, 32'h00030000, 32'hFFFFAAAB, 32'hFFFF0000}; // -1.0 /  3.0
        vecs[7]  = '{32'h00010000, 32'hFFFD0000, 32'hFFFFAAAB, 32'h00010000}; //  1.0 / -3.0
        vecs[8]  = '{32'h00000001, 32'h00030000, 32'h00000000, 32'h00010000}; //  lsb /  3.0
        vecs[9]  = '{32'h00010000, 32'h00000001, 32'h00000000, 32'h00000000}; //  2^32 wraps to 0
        vecs[10] = '{32'h80000000, 32'h00010000, 32'h80000000, 32'h00000000}; //  most negative / 1.0
        vecs[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00010000, 32'h00000000}; //  max / max
        vecs[12] = '{32'hFFFB0000, 32'h00000000, 32'h00000000, 32'hFFFB0000}; // -5.0 /  0

        reset = 1'b1;
        go    = 1'b0;
        left  = '0;
        right = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset quotient", out_quotient, '0);
        check("reset remainder", out_remainder, '0);
        check("reset done", W'(done), '0);
`ifdef FP_SDIV_DBZ_FLAG_EN
        check("reset div_by_zero", W'(div_by_zero), '0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i);

        // Outputs hold after done until the next op.
        repeat (5) @(posedge clk);
        #1;
        check("hold quotient", out_quotient, vecs[12].exp_q);
        check("hold remainder", out_remainder, vecs[12].exp_r);

        // go held high, operands changed during RUN: first result uses captured operands.
        start_op(32'h00060000, 32'h00020000, 1'b1);
        left  = 32'h00010000;
        right = 32'h00030000;
        wait_done(lat);
        check("held-go first latency", W'(lat), W'(LAT));
        check_result("held-go first", 32'h00020000, 32'h00030000, 32'h00000000);
        wait_done(lat);
        check("held-go second latency", W'(lat), W'(LAT + 2));
        check_result("held-go second", 32'h00030000, 32'h00005555, 32'h00010000);
        go = 1'b0;
        @(posedge clk);
        #1;

        // Reset 10 cycles into RUN abandons the divide.
        start_op(32'h00070000, 32'hFFFE0000, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort done", W'(done), '0);
        check("abort quotient", out_quotient, '0);
        check("abort remainder", out_remainder, '0);
        @(negedge clk);
        reset = 1'b0;
        count_done(60, hits);
        check("abort no done pulse", W'(hits), '0);
        run_vec(5);

        // Simultaneous reset and go: reset wins, nothing starts.
        @(negedge clk);
        reset = 1'b1;
        go    = 1'b1;
        left  = 32'h00060000;
        right = 32'h00020000;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        go    = 1'b0;
        count_done(60, hits);
        check("reset+go no done", W'(hits), '0);
        check("reset+go quotient", out_quotient, '0);
        run_vec(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
